// File: rtl/i2c_slave_rx.sv
// rtl/i2c_slave_rx.sv - write-only I2C target: fixed-address match, ACK, byte strobe out
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR  = 7'h42,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       addr_match,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_DATA,
    ST_DATA_ACK,
    ST_IGNORE
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
  logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
  logic                   scl_prev_q, scl_prev_d;
  logic                   sda_prev_q, sda_prev_d;

  state_t      state_q, state_d;
  logic [7:0]  shift_q, shift_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic        sda_oe_q, sda_oe_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        addr_match_q, addr_match_d;
  logic        busy_q, busy_d;

  logic scl_s, sda_s;
  logic scl_rise, scl_fall;
  logic start_det, stop_det;

  // Synchronisers reset to the idle-bus level so reset never fabricates a START.
  always_comb begin
    scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl};
    sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda};
    scl_prev_d = scl_s;
    sda_prev_d = sda_s;
  end

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    sda_oe_d     = sda_oe_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    addr_match_d = addr_match_q;
    busy_d       = busy_q;
    if (stop_det) begin
      state_d      = ST_IDLE;
      shift_d      = 8'h00;
      bit_cnt_d    = 4'd0;
      sda_oe_d     = 1'b0;
      addr_match_d = 1'b0;
      busy_d       = 1'b0;
    end else if (start_det) begin
      state_d      = ST_ADDR;
      shift_d      = 8'h00;
      bit_cnt_d    = 4'd0;
      sda_oe_d     = 1'b0;
      addr_match_d = 1'b0;
      busy_d       = 1'b1;
    end else begin
      case (state_q)
        ST_ADDR, ST_DATA: begin
          if (scl_rise && (bit_cnt_q < 4'd8)) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end else if (scl_fall && (bit_cnt_q == 4'd8)) begin
            if (state_q == ST_ADDR) begin
              if (shift_q == {SLAVE_ADDR, 1'b0}) begin
                state_d  = ST_ADDR_ACK;
                sda_oe_d = 1'b1;
              end else begin
                state_d  = ST_IGNORE;
              end
            end else begin
              rx_data_d  = shift_q;
              rx_valid_d = 1'b1;
              sda_oe_d   = 1'b1;
              state_d    = ST_DATA_ACK;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (scl_fall) begin
            sda_oe_d     = 1'b0;
            addr_match_d = 1'b1;
            bit_cnt_d    = 4'd0;
            state_d      = ST_DATA;
          end
        end
        ST_DATA_ACK: begin
          if (scl_fall) begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = 4'd0;
            state_d   = ST_DATA;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_q   <= '1;
      sda_sync_q   <= '1;
      scl_prev_q   <= 1'b1;
      sda_prev_q   <= 1'b1;
      state_q      <= ST_IDLE;
      shift_q      <= 8'h00;
      bit_cnt_q    <= 4'd0;
      sda_oe_q     <= 1'b0;
      rx_data_q    <= 8'h00;
      rx_valid_q   <= 1'b0;
      addr_match_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      scl_sync_q   <= scl_sync_d;
      sda_sync_q   <= sda_sync_d;
      scl_prev_q   <= scl_prev_d;
      sda_prev_q   <= sda_prev_d;
      state_q      <= state_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      sda_oe_q     <= sda_oe_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      addr_match_q <= addr_match_d;
      busy_q       <= busy_d;
    end
  end

  assign sda        = sda_oe_q ? 1'b0 : 1'bz;
  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign addr_match = addr_match_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave_rx.sv
// tb/tb_i2c_slave_rx.sv - bus-level master model with scoreboarded byte checks for i2c_slave_rx
module tb_i2c_slave_rx;

  localparam int          Q      = 40;
  localparam logic [7:0]  WR_ADR = 8'h84;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic scl = 1'b1;
  logic m_sda_low = 1'b0;
  wire  sda;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       addr_match;
  logic       busy;

  pullup (sda);
  assign sda = m_sda_low ? 1'b0 : 1'bz;

  i2c_slave_rx dut (
    .clk(clk),
    .rst_n(rst_n),
    .scl(scl),
    .sda(sda),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .addr_match(addr_match),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int viol = 0;
  logic [7:0] exp_q[$];
  logic [7:0] data_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Scoreboard monitor: every rx_valid strobe must match the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n && rx_valid) begin
      chk("rx_pending", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) chk("rx_data", {24'd0, rx_data}, {24'd0, exp_q.pop_front()});
    end
  end

  logic sda_p = 1'b1, scl_p = 1'b1, mlow_p = 1'b0, rst_p = 1'b0;
  always @(negedge clk) begin
    if (rst_n && rst_p && scl && scl_p && (sda !== sda_p) && (m_sda_low == mlow_p)) viol++;
    sda_p  = sda;
    scl_p  = scl;
    mlow_p = m_sda_low;
    rst_p  = rst_n;
  end

  task automatic i2c_start();
    m_sda_low = 1'b0; #Q;
    scl = 1'b1;       #Q;
    m_sda_low = 1'b1; #Q;
    scl = 1'b0;       #Q;
  endtask

  task automatic i2c_stop();
    m_sda_low = 1'b1; #Q;
    scl = 1'b1;       #Q;
    m_sda_low = 1'b0; #Q;
    #Q;
  endtask

  task automatic write_bit(input logic b);
    m_sda_low = ~b; #Q;
    scl = 1'b1;     #(2*Q);
    scl = 1'b0;     #Q;
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string name);
    logic acked;
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    m_sda_low = 1'b0; #Q;
    scl = 1'b1;       #Q;
    acked = (sda === 1'b0);
    #Q;
    scl = 1'b0;       #Q;
    chk(name, {31'd0, acked}, {31'd0, exp_ack});
  endtask

  // Reference model: a transfer is accepted only if the first byte equals the write address;
  // every complete data byte of an accepted transfer is delivered and ACKed, partial bytes never.
  task automatic txn(input logic [7:0] a, input int partial, input bit do_stop);
    logic acc;
    acc = (a == WR_ADR);
    i2c_start();
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("match_after_start", {31'd0, addr_match}, 32'd0);
    write_byte(a, acc, "addr_ack");
    chk("addr_match", {31'd0, addr_match}, {31'd0, acc});
    while (data_q.size() != 0) begin
      logic [7:0] d;
      d = data_q.pop_front();
      if (acc) exp_q.push_back(d);
      write_byte(d, acc, "data_ack");
    end
    for (int i = 0; i < partial; i++) write_bit(1'($urandom_range(0, 1)));
    if (do_stop) begin
      i2c_stop();
      chk("busy_after_stop", {31'd0, busy}, 32'd0);
      chk("match_after_stop", {31'd0, addr_match}, 32'd0);
    end
  endtask

  initial begin
    @(negedge clk); #2;
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_addr_match", {31'd0, addr_match}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sda", {31'd0, sda}, 32'd1);
    #20 rst_n = 1'b1;
    #Q;

    data_q.push_back(8'hA5);
    txn(WR_ADR, 0, 1'b1);
    chk("rx_data_held", {24'd0, rx_data}, 32'hA5);

    data_q.push_back(8'h5A);
    txn(8'h86, 0, 1'b1);
    chk("rx_data_after_foreign", {24'd0, rx_data}, 32'hA5);

    data_q.push_back(8'h33);
    txn(8'h85, 0, 1'b1);

    data_q.push_back(8'h11);
    data_q.push_back(8'h22);
    data_q.push_back(8'h33);
    txn(WR_ADR, 0, 1'b1);

    txn(WR_ADR, 4, 1'b0);
    data_q.push_back(8'h7E);
    txn(WR_ADR, 0, 1'b1);
    chk("rx_data_after_partial", {24'd0, rx_data}, 32'h7E);

    i2c_start();
    write_byte(WR_ADR, 1'b1, "rst_addr_ack");
    exp_q.push_back(8'h3C);
    for (int i = 7; i >= 0; i--) write_bit(1'(8'h3C >> i));
    m_sda_low = 1'b0; #Q;
    scl = 1'b1;       #Q;
    chk("ack_before_reset", {31'd0, sda}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("reset_sda_released", {31'd0, sda}, 32'd1);
    chk("reset_rx_data", {24'd0, rx_data}, 32'd0);
    chk("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("reset_addr_match", {31'd0, addr_match}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    #(Q-1);
    rst_n = 1'b1;
    scl = 1'b0;       #Q;
    write_byte(WR_ADR, 1'b0, "no_start_addr_nack");
    write_byte(8'h5A, 1'b0, "no_start_data_nack");
    chk("no_start_busy", {31'd0, busy}, 32'd0);
    chk("no_start_match", {31'd0, addr_match}, 32'd0);
    i2c_stop();

    for (int t = 0; t < 20; t++) begin
      int sel, n, part;
      logic [7:0] a;
      sel = $urandom_range(0, 3);
      a = (sel < 2) ? WR_ADR : (sel == 2) ? 8'h85 : 8'($urandom_range(0, 255));
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) data_q.push_back(8'($urandom_range(0, 255)));
      part = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      txn(a, part, 1'($urandom_range(0, 1)));
    end
    i2c_stop();
    chk("final_busy", {31'd0, busy}, 32'd0);

    #(4*Q);
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    chk("sda_stable_while_scl_high", viol, 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
